// File: rtl/pov_column_sequencer.sv
// pov_column_sequencer
//   Scans one angular slice of the persistence-of-vision display. It walks the
//   scan indices, skips the ones that are not lit at this angle, fetches
//   NUM_CHANNELS columns per lit index from the selected content source, and
//   hands them to the panel driver over a valid/ready handshake.
//
// Ports
//   clk_in, rst_in   clock, synchronous active-low reset
//   theta            current angular slice; any change starts a new sweep
//   mode_sel         content source select (out-of-range selects source 0)
//   col_mask         bit i set = scan index i lit at this theta
//   lookup_idx       scan index presented to every content lookup
//   src_cols         lookup data, one cycle behind lookup_idx
//   out_cols         pixel columns, one NUM_ROWS word per channel
//   out_col_num      physical column number per channel
//   out_valid/ready  handshake to the panel driver
//   sweep_done       pulse when the last index of a slice is accepted/skipped
//   overrun          pulse when theta moves before the sweep completes
//   overrun_cnt      saturating overrun count
module pov_column_sequencer #(
  parameter int NUM_ROWS     = 64,
  parameter int NUM_COLS     = 64,
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_SOURCES  = 2,
  parameter int THETA_RES    = 8,
  parameter int CNT_W        = 8
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic [THETA_RES-1:0]                         theta,
  input  logic [$clog2(NUM_SOURCES)-1:0]               mode_sel,
  input  logic [NUM_COLS/NUM_CHANNELS-1:0]             col_mask,
  output logic [$clog2(NUM_COLS/NUM_CHANNELS)-1:0]     lookup_idx,
  input  logic [NUM_SOURCES*NUM_CHANNELS*NUM_ROWS-1:0] src_cols,
  output logic [NUM_CHANNELS*NUM_ROWS-1:0]             out_cols,
  output logic [NUM_CHANNELS*$clog2(NUM_COLS)-1:0]     out_col_num,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         sweep_done,
  output logic                                         overrun,
  output logic [CNT_W-1:0]                             overrun_cnt
);

  localparam int unsigned SCAN_RATE = NUM_COLS / NUM_CHANNELS;
  localparam int unsigned IDX_W     = $clog2(SCAN_RATE);
  localparam int unsigned COL_W     = $clog2(NUM_COLS);
  localparam int unsigned SEL_W     = $clog2(NUM_SOURCES);
  localparam int unsigned SLICE_W   = NUM_CHANNELS * NUM_ROWS;
  localparam int unsigned COLNUM_W  = NUM_CHANNELS * COL_W;
  localparam logic [SEL_W:0]   NSRC     = (SEL_W + 1)'(NUM_SOURCES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCAN_RATE - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  state_t                 state;
  logic [THETA_RES-1:0]   theta_q;
  logic [SCAN_RATE-1:0]   mask_q;
  logic [SEL_W-1:0]       mode_q;
  logic [IDX_W-1:0]       scan_idx;

  logic                   theta_chg;
  logic                   last_idx;
  logic                   accept;
  logic                   in_sweep;
  logic [SEL_W-1:0]       src_sel;
  logic [SLICE_W-1:0]     fetch_cols;
  logic [COLNUM_W-1:0]    next_col_num;

  assign theta_chg  = (theta != theta_q);
  assign last_idx   = (scan_idx == LAST_IDX);
  assign accept     = (state == PRESENT) && out_valid && out_ready;
  assign in_sweep   = (state == SCAN) || (state == FETCH) || (state == PRESENT);
  assign lookup_idx = scan_idx;

  always_comb begin
    src_sel = '0;
    if ({1'b0, mode_q} < NSRC) begin
      src_sel = mode_q;
    end
  end

  always_comb begin
    fetch_cols = '0;
    for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
      if (src_sel == SEL_W'(s)) begin
        fetch_cols = src_cols[s*SLICE_W +: SLICE_W];
      end
    end
  end

  // Channel c carries column scan_idx + c*SCAN_RATE.
  always_comb begin
    next_col_num = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      next_col_num[c*COL_W +: COL_W] = COL_W'(scan_idx) + COL_W'(c * SCAN_RATE);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      theta_q     <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      scan_idx    <= '0;
      out_cols    <= '0;
      out_col_num <= '0;
      out_valid   <= 1'b0;
      sweep_done  <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      theta_q    <= theta;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;

      if ((state == IDLE) || theta_chg) begin
        // A restart pre-empts everything. An acceptance of the final index in
        // the same cycle still completes the old sweep, so it is not an overrun.
        mask_q    <= col_mask;
        mode_q    <= mode_sel;
        scan_idx  <= '0;
        out_valid <= 1'b0;
        state     <= SCAN;
        if (accept && last_idx) begin
          sweep_done <= 1'b1;
        end else if (in_sweep) begin
          overrun <= 1'b1;
          if (overrun_cnt != '1) begin
            overrun_cnt <= overrun_cnt + 1'b1;
          end
        end
      end else begin
        case (state)
          SCAN: begin
            if (mask_q[scan_idx]) begin
              state <= FETCH;
            end else if (last_idx) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
          end
          FETCH: begin
            out_cols    <= fetch_cols;
            out_col_num <= next_col_num;
            out_valid   <= 1'b1;
            state       <= PRESENT;
          end
          PRESENT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (last_idx) begin
                state      <= DONE;
                sweep_done <= 1'b1;
              end else begin
                scan_idx <= scan_idx + 1'b1;
                state    <= SCAN;
              end
            end
          end
          DONE: begin
            out_valid <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pov_column_sequencer.sv
// Bench for pov_column_sequencer: random content ROM with one-cycle lookup
// latency, scoreboard queue of expected transfers, monitor that pops on every
// accepted handshake.
module tb_pov_column_sequencer;

  localparam int NR    = 64;
  localparam int NC    = 64;
  localparam int NCH   = 2;
  localparam int NS    = 3;
  localparam int TR    = 8;
  localparam int CW    = 8;
  localparam int SR    = NC / NCH;
  localparam int IDX_W = $clog2(SR);
  localparam int COL_W = $clog2(NC);
  localparam int SEL_W = $clog2(NS);

  logic                    clk = 1'b0;
  logic                    rst_in;
  logic [TR-1:0]           theta;
  logic [SEL_W-1:0]        mode_sel;
  logic [SR-1:0]           col_mask;
  logic [IDX_W-1:0]        lookup_idx;
  logic [NS*NCH*NR-1:0]    src_cols = '0;
  logic [NCH*NR-1:0]       out_cols;
  logic [NCH*COL_W-1:0]    out_col_num;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sweep_done;
  logic                    overrun;
  logic [CW-1:0]           overrun_cnt;

  pov_column_sequencer #(
    .NUM_ROWS    (NR),
    .NUM_COLS    (NC),
    .NUM_CHANNELS(NCH),
    .NUM_SOURCES (NS),
    .THETA_RES   (TR),
    .CNT_W       (CW)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .theta       (theta),
    .mode_sel    (mode_sel),
    .col_mask    (col_mask),
    .lookup_idx  (lookup_idx),
    .src_cols    (src_cols),
    .out_cols    (out_cols),
    .out_col_num (out_col_num),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sweep_done  (sweep_done),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [NCH*NR-1:0]    cols;
    logic [NCH*COL_W-1:0] nums;
  } xfer_t;

  logic [NR-1:0] rom [NS][NC];
  xfer_t         sb[$];
  xfer_t         mon_e;
  int            tests = 0;
  int            fails = 0;
  int            done_seen = 0;
  int            ovr_seen = 0;
  int            model_ovr = 0;

  // Content lookups: registered read of lookup_idx.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NCH; c++)
        src_cols[(s*NCH + c)*NR +: NR] <= rom[s][int'(lookup_idx) + c*SR];
  end

  function automatic xfer_t model_xfer(input int idx, input int mode);
    xfer_t x;
    int    src;
    int    col;
    src = (mode < NS) ? mode : 0;
    for (int c = 0; c < NCH; c++) begin
      col = idx + c*SR;
      x.cols[c*NR +: NR]       = rom[src][col];
      x.nums[c*COL_W +: COL_W] = COL_W'(col);
    end
    return x;
  endfunction

  task automatic push_sweep(input logic [SR-1:0] mask, input int mode);
    for (int i = 0; i < SR; i++)
      if (mask[i]) sb.push_back(model_xfer(i, mode));
  endtask

  // Always-ready sink: 3 cycles per lit index, 1 per skipped index.
  function automatic int sweep_cycles(input logic [SR-1:0] mask);
    int pop;
    pop = $countones(mask);
    return 3*pop + (SR - pop);
  endfunction

  task automatic check(input string name, input logic [NCH*NR-1:0] act, input logic [NCH*NR-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_until_done(input string name, input int budget, input bit rnd, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (sweep_done === 1'b1) break;
      if (n >= budget) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: no sweep_done after %0d cycles", name, n);
        break;
      end
    end
  endtask

  // Monitor: sample just before each rising edge, after inputs have settled.
  initial forever begin
    @(negedge clk);
    #4;
    if (rst_in === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: col_num %0h, expected no transfer", out_col_num);
      end else begin
        mon_e = sb.pop_front();
        check("xfer_cols", out_cols, mon_e.cols);
        check("xfer_col_num", NCH*NR'(out_col_num), NCH*NR'(mon_e.nums));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (sweep_done === 1'b1) done_seen++;
    if (overrun === 1'b1) ovr_seen++;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int            n;
    int            d0;
    int            o0;
    int            md;
    bit            found;
    logic [SR-1:0] m;
    xfer_t         x0;

    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NC; c++)
        rom[s][c] = {$urandom, $urandom};

    rst_in = 1'b0; theta = 8'h10; mode_sel = '0; col_mask = '1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), '0);
    check("rst_lookup_idx", 128'(lookup_idx), '0);
    check("rst_overrun_cnt", 128'(overrun_cnt), '0);
    check("rst_out_cols", out_cols, '0);
    check("rst_out_col_num", 128'(out_col_num), '0);
    check("rst_sweep_done", 128'(sweep_done), '0);

    // Full mask from reset release.
    d0 = done_seen;
    push_sweep('1, 0);
    rst_in = 1'b1;
    run_until_done("full", 200, 0, n);
    check("full_cycles", 128'(n), 128'(sweep_cycles('1) + 1));
    check("full_sb_empty", 128'(sb.size()), '0);
    repeat (3) @(negedge clk);
    check("full_done_once", 128'(done_seen - d0), 128'(1));
    check("full_overrun_cnt", 128'(overrun_cnt), '0);

    // Sparse mask, source 1; mid-sweep mask/mode changes must be ignored.
    push_sweep(32'h0000_0005, 1);
    col_mask = 32'h0000_0005; mode_sel = 2'd1; theta = 8'h20;
    repeat (2) @(negedge clk);
    col_mask = '1; mode_sel = 2'd0;
    run_until_done("sparse", 100, 0, n);
    check("sparse_cycles", 128'(n + 2), 128'(sweep_cycles(32'h5) + 1));
    check("sparse_sb_empty", 128'(sb.size()), '0);

    // Stall on the first transfer, then random backpressure.
    m = $urandom; m[0] = 1'b1;
    out_ready = 1'b0;
    push_sweep(m, 2);
    x0 = model_xfer(0, 2);
    col_mask = m; mode_sel = 2'd2; theta = 8'h30;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    check("stall_valid_seen", 128'(found), 128'(1));
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", 128'(out_valid), 128'(1));
      check("stall_cols", out_cols, x0.cols);
      check("stall_col_num", 128'(out_col_num), 128'(x0.nums));
      @(negedge clk);
    end
    run_until_done("stall", 1000, 1, n);
    check("stall_sb_empty", 128'(sb.size()), '0);

    // Overrun while index 5 is presented; mask change at index 3 is ignored.
    out_ready = 1'b0;
    col_mask = '1; mode_sel = 2'd0; theta = 8'h10;
    push_sweep('1, 0);
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (out_valid) begin
        if (out_col_num[COL_W-1:0] == 6'd5) found = 1;
        else begin
          if (out_col_num[COL_W-1:0] == 6'd3) col_mask = 32'h0000_0101;
          out_ready = 1'b1;
        end
      end
    end
    check("ovr_reach_idx5", 128'(found), 128'(1));
    sb.delete();
    push_sweep(32'h0000_0101, 0);
    theta = 8'h11;
    model_ovr++;
    @(negedge clk);
    check("ovr_pulse", 128'(overrun), 128'(1));
    check("ovr_cnt", 128'(overrun_cnt), 128'(model_ovr));
    out_ready = 1'b1;
    run_until_done("ovr_restart", 200, 0, n);
    check("ovr_restart_cycles", 128'(n), 128'(sweep_cycles(32'h101)));
    check("ovr_sb_empty", 128'(sb.size()), '0);

    // theta change in the same cycle as acceptance of the last index.
    col_mask = '1; mode_sel = 2'd1; theta = 8'h40;
    push_sweep('1, 1);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (out_valid && out_col_num[COL_W-1:0] == 6'd31) found = 1;
    end
    check("last_reach_idx31", 128'(found), 128'(1));
    m = $urandom;
    push_sweep(m, 2);
    col_mask = m; mode_sel = 2'd2; theta = 8'h41;
    @(negedge clk);
    check("last_sweep_done", 128'(sweep_done), 128'(1));
    check("last_no_overrun", 128'(overrun), '0);
    check("last_ovr_cnt", 128'(overrun_cnt), 128'(model_ovr));
    run_until_done("last_restart", 300, 0, n);
    check("last_restart_cycles", 128'(n), 128'(sweep_cycles(m)));
    check("last_sb_empty", 128'(sb.size()), '0);

    // Force 300 overruns: saturation at 255.
    col_mask = '0;
    theta = theta + 1'b1;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      theta = theta + 1'b1;
      if (model_ovr < 255) model_ovr++;
      @(negedge clk);
      check("sat_pulse", 128'(overrun), 128'(1));
      check("sat_cnt", 128'(overrun_cnt), 128'(model_ovr));
    end
    run_until_done("sat_tail", 100, 0, n);
    check("sat_tail_cycles", 128'(n), 128'(sweep_cycles('0)));
    check("sat_final_cnt", 128'(overrun_cnt), 128'(255));

    // Reset mid-handshake.
    out_ready = 1'b0; col_mask = '1; mode_sel = 2'd0; theta = 8'h55;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    check("rst2_valid_seen", 128'(found), 128'(1));
    rst_in = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 128'(out_valid), '0);
    check("rst2_sweep_done", 128'(sweep_done), '0);
    check("rst2_overrun", 128'(overrun), '0);
    check("rst2_overrun_cnt", 128'(overrun_cnt), '0);
    check("rst2_lookup_idx", 128'(lookup_idx), '0);
    check("rst2_out_cols", out_cols, '0);
    check("rst2_out_col_num", 128'(out_col_num), '0);
    model_ovr = 0;
    o0 = ovr_seen;

    // Random sweeps with random backpressure and mode (3 falls back to source 0).
    for (int r = 0; r < 6; r++) begin
      m = $urandom;
      md = $urandom_range(0, 3);
      push_sweep(m, md);
      col_mask = m; mode_sel = 2'(md);
      if (r == 0) rst_in = 1'b1;
      else theta = theta + 8'd3;
      run_until_done("rand", 1000, 1, n);
      check("rand_sb_empty", 128'(sb.size()), '0);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rand_no_overrun", 128'(ovr_seen - o0), '0);
    check("rand_overrun_cnt", 128'(overrun_cnt), 128'(model_ovr));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
